// File: rtl/piano_pkg.sv
// Note divisor table for the piano tone generator.
// Each divisor is a full square-wave period in 50 MHz clock cycles.
package piano_pkg;

    localparam int NOTE_W = 18;

    localparam int DO4  = 0;
    localparam int RE4  = 1;
    localparam int MI4  = 2;
    localparam int FA4  = 3;
    localparam int SOL4 = 4;
    localparam int LA4  = 5;
    localparam int SI4  = 6;
    localparam int DO5  = 7;

    typedef logic [NOTE_W-1:0] note_div_t;

    localparam note_div_t NOTE_DIV [0:7] = '{
        18'd191113, 18'd170263, 18'd151687, 18'd143173,
        18'd127553, 18'd113637, 18'd101239, 18'd95557
    };

endpackage

// File: rtl/piano_voices_note_osc.sv
// Single-key square-wave oscillator. The period is captured at start and at
// every wrap, so a shift change never cuts a period short.
module note_osc #(
    parameter int DIV_W   = 18,
    parameter int SHIFT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [DIV_W-1:0]   div,
    input  logic [SHIFT_W-1:0] shift,
    output logic               tone
);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_p_lat;
    logic             r_active;

    logic [DIV_W-1:0] w_p_new;
    logic [DIV_W-1:0] w_p_nxt;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic             w_wrap;

    assign w_p_new = div >> shift;
    // Wrap test in one extra bit so a degenerate period of 0 or 1 still wraps.
    assign w_wrap  = ({1'b0, r_cnt} + {{DIV_W{1'b0}}, 1'b1}) >= {1'b0, r_p_lat};

    always_comb begin
        w_p_nxt   = r_p_lat;
        w_cnt_nxt = r_cnt + DIV_W'(1);
        if (!r_active || w_wrap) begin
            w_p_nxt   = w_p_new;
            w_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_p_lat  <= '0;
            tone     <= 1'b0;
        end else if (!run) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
            tone     <= 1'b0;
        end else begin
            r_active <= 1'b1;
            r_cnt    <= w_cnt_nxt;
            r_p_lat  <= w_p_nxt;
            tone     <= w_cnt_nxt < (w_p_nxt >> 1);
        end
    end

endmodule

// File: rtl/piano_voices.sv
// Polyphonic square-wave generator: key sync, voice limiter, per-key
// oscillators, tone mixer and first-order sigma-delta speaker output.
module piano_voices #(
    parameter int NKEYS     = 8,
    parameter int NVOICES   = 4,
    parameter int DIV_W     = 18,
    parameter int SIM_SHIFT = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NKEYS-1:0]               keys,
    input  logic [1:0]                     octave,
    output logic [NKEYS-1:0]               tone,
    output logic [$clog2(NVOICES+1)-1:0]   mix_sum,
    output logic                           dac_out
);

    import piano_pkg::*;

    localparam int MIX_W   = $clog2(NVOICES + 1);
    localparam int ACC_W   = $clog2(2 * NVOICES + 1);
    localparam int SHIFT_W = $clog2(SIM_SHIFT + 4) + 1;

    logic [NKEYS-1:0]   r_sync1;
    logic [NKEYS-1:0]   r_ks;
    logic [ACC_W-1:0]   r_acc;

    logic [NKEYS-1:0]   w_sounding;
    logic [3:0]         w_nsel;
    logic [SHIFT_W-1:0] w_shift;
    logic [MIX_W-1:0]   w_pop;
    logic [ACC_W:0]     w_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_ks    <= '0;
        end else begin
            r_sync1 <= keys;
            r_ks    <= r_sync1;
        end
    end

    // Lowest-index pressed keys win the available voices.
    always_comb begin
        w_sounding = '0;
        w_nsel     = '0;
        for (int k = 0; k < NKEYS; k++) begin
            if (r_ks[k] && (w_nsel < 4'(NVOICES))) begin
                w_sounding[k] = 1'b1;
                w_nsel        = w_nsel + 4'd1;
            end
        end
    end

    assign w_shift = SHIFT_W'(octave) + SHIFT_W'(SIM_SHIFT);

    for (genvar k = 0; k < NKEYS; k++) begin : g_osc
        note_osc #(
            .DIV_W   (DIV_W),
            .SHIFT_W (SHIFT_W)
        ) u_osc (
            .clk   (clk),
            .rst   (rst),
            .run   (w_sounding[k]),
            .div   (DIV_W'(NOTE_DIV[k])),
            .shift (w_shift),
            .tone  (tone[k])
        );
    end

    always_comb begin
        w_pop = '0;
        for (int k = 0; k < NKEYS; k++) begin
            w_pop = w_pop + MIX_W'(tone[k]);
        end
    end

    assign w_s = {1'b0, r_acc} + (ACC_W+1)'(mix_sum);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mix_sum <= '0;
            dac_out <= 1'b0;
            r_acc   <= '0;
        end else begin
            mix_sum <= w_pop;
            if (w_s >= (ACC_W+1)'(NVOICES)) begin
                dac_out <= 1'b1;
                r_acc   <= ACC_W'(w_s - (ACC_W+1)'(NVOICES));
            end else begin
                dac_out <= 1'b0;
                r_acc   <= ACC_W'(w_s);
            end
        end
    end

endmodule

// File: tb/tb_piano_voices.sv
// Randomised and directed bench for piano_voices against a time-based
// reference model (phase = cycles since period start, dac = cumulative-sum carries).
module tb_piano_voices;

    localparam int NK    = 8;
    localparam int NV    = 4;
    localparam int SHIFT = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [NK-1:0] keys;
    logic [1:0]    octave;
    logic [NK-1:0] tone;
    logic [2:0]    mix_sum;
    logic          dac_out;

    int n_checks = 0;
    int n_errors = 0;

    piano_voices #(
        .NKEYS     (NK),
        .NVOICES   (NV),
        .DIV_W     (18),
        .SIM_SHIFT (SHIFT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .keys    (keys),
        .octave  (octave),
        .tone    (tone),
        .mix_sum (mix_sum),
        .dac_out (dac_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    int base_div [8] = '{191113, 170263, 151687, 143173, 127553, 113637, 101239, 95557};

    // Reference model state
    logic [NK-1:0] m_sync1, m_ks, m_tone;
    int            m_mix;
    logic          m_dac;
    longint        m_cum;
    longint        m_cyc;
    bit            m_act   [NK];
    longint        m_start [NK];
    int            m_per   [NK];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [NK-1:0] limit(input logic [NK-1:0] v);
        int n = 0;
        limit = '0;
        for (int i = 0; i < NK; i++) begin
            if (v[i] && n < NV) begin
                limit[i] = 1'b1;
                n++;
            end
        end
    endfunction

    task automatic model_reset();
        m_sync1 = '0; m_ks = '0; m_tone = '0;
        m_mix = 0; m_dac = 1'b0; m_cum = 0; m_cyc = 0;
        for (int k = 0; k < NK; k++) begin
            m_act[k] = 1'b0; m_start[k] = 0; m_per[k] = 0;
        end
    endtask

    task automatic step();
        logic [NK-1:0] k_in, snd, t_old;
        logic [1:0]    o_in;
        int            mix_old;
        longint        cum_new;
        k_in = keys;
        o_in = octave;
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            snd     = limit(m_ks);
            t_old   = m_tone;
            mix_old = m_mix;
            for (int k = 0; k < NK; k++) begin
                if (!snd[k]) begin
                    m_act[k]  = 1'b0;
                    m_tone[k] = 1'b0;
                end else begin
                    if (!m_act[k] || (m_cyc - m_start[k]) >= m_per[k]) begin
                        m_act[k]   = 1'b1;
                        m_start[k] = m_cyc;
                        m_per[k]   = base_div[k] >> (o_in + SHIFT);
                    end
                    m_tone[k] = (m_cyc - m_start[k]) < (m_per[k] / 2);
                end
            end
            m_mix   = $countones(t_old);
            cum_new = m_cum + mix_old;
            m_dac   = (cum_new / NV) != (m_cum / NV);
            m_cum   = cum_new;
            m_ks    = m_sync1;
            m_sync1 = k_in;
            m_cyc++;
        end
        check("tone", tone, m_tone);
        check("mix_sum", mix_sum, m_mix);
        check("dac_out", dac_out, m_dac);
    endtask

    task automatic run_len(input int idx, input logic lvl, output int n);
        n = 0;
        while (tone[idx] === lvl && n < 2000) begin
            n++;
            step();
        end
    endtask

    task automatic wait_level(input int idx, input logic lvl);
        int i = 0;
        while (tone[idx] !== lvl && i < 2000) begin
            i++;
            step();
        end
        check("wait_level", tone[idx], lvl);
    endtask

    initial begin
        int h, l;
        logic [7:0] pat, seen;

        rst = 1'b1; keys = '0; octave = 2'd0;
        model_reset();
        repeat (3) step();
        check("reset_tone", tone, 0);
        check("reset_dac", dac_out, 0);
        rst = 1'b0;
        repeat (5) step();
        check("idle_tone", tone, 0);

        // Single note latency and sigma-delta pattern from a clean accumulator
        keys = 8'h01;
        step(); step();
        check("start_lat2", tone[0], 1'b0);
        step();
        check("start_lat3", tone[0], 1'b1);
        step();
        check("mix_lat", mix_sum, 1);
        pat = '0;
        for (int i = 0; i < 8; i++) begin
            step();
            pat[i] = dac_out;
        end
        check("sd_pattern", pat, 8'h88);

        wait_level(0, 1'b0);
        wait_level(0, 1'b1);
        run_len(0, 1'b1, h); check("do4_high", h, 93);
        run_len(0, 1'b0, l); check("do4_low", l, 93);

        // Release during a high phase
        repeat (5) step();
        keys = 8'h00;
        step(); step();
        check("rel_lat2", tone[0], 1'b1);
        step();
        check("rel_lat3", tone[0], 1'b0);
        check("rel_mix_hold", mix_sum, 1);
        step();
        check("rel_mix_drop", mix_sum, 0);

        // Odd period and octave change mid-high
        keys = 8'h80;
        wait_level(7, 1'b1);
        run_len(7, 1'b1, h); check("do5_high", h, 46);
        run_len(7, 1'b0, l); check("do5_low", l, 47);
        repeat (10) step();
        octave = 2'd1;
        run_len(7, 1'b1, h); check("oct_rest_high", h + 10, 46);
        run_len(7, 1'b0, l); check("oct_old_low", l, 47);
        run_len(7, 1'b1, h); check("oct_new_high", h, 23);
        run_len(7, 1'b0, l); check("oct_new_low", l, 23);

        // Voice limit and promotion on release
        octave = 2'd0;
        keys   = 8'hFF;
        repeat (4) step();
        seen = '0;
        repeat (400) begin
            step();
            seen |= tone;
        end
        check("vl_mask", seen, 8'h0F);
        keys = 8'hFD;
        step(); step();
        check("promo_lat2", tone[4], 1'b0);
        step();
        check("promo_lat3", tone[4], 1'b1);

        // Asynchronous reset mid-run
        repeat (20) step();
        #3;
        rst = 1'b1;
        #1;
        check("async_tone", tone, 0);
        check("async_mix", mix_sum, 0);
        check("async_dac", dac_out, 0);
        keys = '0;
        repeat (3) step();
        rst = 1'b0;
        repeat (10) step();
        check("post_reset_tone", tone, 0);

        // Random key and octave activity
        repeat (4000) begin
            step();
            if ($urandom_range(39, 0) == 0) keys = NK'($urandom);
            if ($urandom_range(149, 0) == 0) octave = 2'($urandom);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/piano_voices.md
# piano_voices

Polyphonic square-wave tone generator for the piano keyboard. Eight note keys (Do4..Do5) each drive a dedicated divider oscillator. A voice limiter lets at most NVOICES keys sound at once, and a global octave shift applies to all keys. Sounding tones are summed and converted to a 1-bit first-order sigma-delta stream for the speaker pin; per-key tones stay available for LEDs and debug.

## Interface
- NKEYS, 8: number of keys, 1..8; bit k maps to divisor table entry k.
- NVOICES, 4: maximum simultaneously sounding keys, 1..NKEYS.
- DIV_W, 18: divisor/counter width.
- SIM_SHIFT, 0: extra right shift applied to every divisor; nonzero only in simulation.
- clk  in  1  system clock, 50 MHz (divisor table is computed for 50 MHz)
- rst  in  1  reset, asynchronous, active-high
- keys  in  NKEYS  raw key levels, 1 = pressed, asynchronous to clk
- octave  in  2  octave shift 0..3; divides the period by 2^octave
- tone  out  NKEYS  per-key square wave, 0 when the key is not sounding
- mix_sum  out  $clog2(NVOICES+1)  count of sounding tones currently high
- dac_out  out  1  sigma-delta audio bit

## Operation
- Reset (async, active-high) clears the synchronizers, counters, tone, mix_sum, dac_out and the accumulator, all to 0.
- keys pass through a 2-flop synchronizer per bit, giving ks.
- Voice limiter (combinational on ks): sounding = the lowest-index NVOICES set bits of ks; higher set bits are ignored. Example: ks=8'b1111_1000 with NVOICES=4 gives sounding=8'b0111_1000.
- Per-key oscillator k:
  - Base divisor D[k] is Do4 191113, Re4 170263, Mi4 151687, Fa4 143173, Sol4 127553, La4 113637, Si4 101239, Do5 95557.
  - Period P = D[k] >> (octave + SIM_SHIFT). This is latched into a per-key register p_lat when the key starts sounding and at every counter wrap. An octave change therefore never truncates a period in progress.
  - While sounding: cnt runs 0..p_lat-1 and wraps. tone[k] = 1 when cnt < p_lat>>1, else 0 (registered).
  - Not sounding: cnt=0, tone[k]=0, p_lat reloads next start.
  - When a key leaves sounding (release or voice-limited out), tone drops to 0 on the next clock. When it re-enters, the phase restarts at cnt=0.
- Mixer: mix_sum = popcount(tone), registered.
- Sigma-delta: acc width $clog2(2*NVOICES+1).
  - Each cycle s = acc + mix_sum.
  - If s >= NVOICES then dac_out=1 and acc = s - NVOICES.
  - Otherwise dac_out=0 and acc = s.

## Timing
- keys to sounding: 2 cycles (synchronizer).
- sounding rising to tone[k]=1: +1 cycle.
- tone to mix_sum: 1 cycle. mix_sum to dac_out: 1 cycle.
- Total from key edge at the synchronizer input to the first dac contribution: 5 cycles.
- Simultaneous press and release of different keys in the same cycle: the limiter re-evaluates in that cycle. A lower key freed by release can promote a held higher key, which starts at cnt=0.
- Octave change mid-period: the current period completes with the old P. The new P applies from the wrap onward.
- Reset asserted mid-tone: all outputs are 0 asynchronously. After release, oscillators start from cnt=0.
- If P odd: high for floor(P/2) cycles, low for ceil(P/2).

## Structure
- Package piano_pkg holds the localparam divisor array NOTE_DIV[0:7] (18-bit) and the note index constants DO4..DO5.
- Sub-module note_osc has inputs clk, rst, run, div, shift and output tone; it contains cnt, p_lat and the compare logic. It is instantiated NKEYS times via generate.
- The limiter, popcount and sigma-delta stay in the top level.

## Test plan
- Reset: assert rst mid-run → tone=0, mix_sum=0 and dac_out=0 immediately. Release rst → all remain 0 with keys=0.
- Single note, SIM_SHIFT=10, octave=0: hold keys[0] → tone[0] has period 186 (high 93, low 93). First high occurs 3 cycles after the key edge.
- Odd period: keys[7] (Do5), SIM_SHIFT=10 → P=93, high 46, low 47. Set octave=1 mid-high → the current 93-cycle period completes, then P=46 (23/23).
- Voice limit, NVOICES=4: keys=8'hFF → only tone[3:0] toggle. Release keys[1] → tone[4] starts at cnt=0 3 cycles later.
- Sigma-delta: only Do4 sounding, during its high half (mix_sum=1, NVOICES=4) → dac_out pattern 0,0,0,1 repeating. During the low half → dac_out=0.
- Release: drop keys[0] during a high phase → tone[0]=0 exactly 3 cycles after the edge and mix_sum decrements 1 cycle later.
